pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS32 core.
- Arbitrates stall requests from ID (load-use) and EX (busy and multi-cycle ops such as div/madd).
- Sequences multi-cycle EX operations with an internal down-counter.
- Generates the per-stage stall vector and the flush/redirect consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.

Parameters:
- CNT_W, 6: width of the multi-cycle latency counter; supports latencies up to 2^CNT_W-1 cycles.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- stallreq_from_id  in  1  level; ID requests a stall this cycle (load-use hazard).
- stallreq_from_ex  in  1  level; EX is busy this cycle.
- ex_mc_start  in  1  pulse; EX begins a fixed-latency multi-cycle op.
- ex_mc_cycles  in  CNT_W  latency N of that op; sampled only with ex_mc_start.
- flush_req  in  1  exception/redirect request from MEM.
- new_pc_i  in  32  redirect target accompanying flush_req.
- stall  out  6  stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- flush  out  1  clear all pipeline registers this cycle.
- new_pc  out  32  redirect PC; valid while flush=1, otherwise 0.
- mc_done  out  1  one-cycle pulse; the multi-cycle op completed and EX may latch its result.
- busy  out  1  high while the FSM is in MC_WAIT.
- stall_cnt  out  32  stall performance counter (see Optional Feature).

Behaviour:
- FSM states:
  - RUN (reset state).
  - MC_WAIT.
- Registered elements: state, counter cnt[CNT_W-1:0], and the mc_done flag.
- stall, flush and new_pc are combinational (Mealy) from the current state and inputs, with zero latency. The pipeline registers must see them in the same cycle.
- Priority, highest first:
  - rst
  - flush_req
  - EX stall: MC_WAIT, or ex_mc_start in RUN, or stallreq_from_ex
  - stallreq_from_id
- Stall encodings:
  - EX stall: 6'b001111.
  - ID stall only: 6'b000111.
  - None: 6'b000000.
- flush_req=1 in any state:
  - flush=1, new_pc=new_pc_i, stall=6'b000000.
  - Next state is RUN; cnt is cleared.
  - An in-flight multi-cycle op is aborted and no mc_done follows.
- RUN with ex_mc_start=1 and no flush:
  - Let N = ex_mc_cycles, with N=0 treated as 1.
  - stall=EX encoding this cycle.
  - If N=1: stay in RUN and pulse mc_done next cycle.
  - Otherwise: cnt<=N-1 and go to MC_WAIT.
- MC_WAIT:
  - stall=EX encoding every cycle.
  - cnt decrements each cycle.
  - When cnt==1, next state is RUN and mc_done=1 the following cycle.
  - Total stall cycles = N, counting the start cycle.
  - mc_done is asserted in cycle N, and stall is 0 in that cycle unless another request is present.
- ex_mc_start while in MC_WAIT is ignored. The EX owner must not issue it.
- stallreq_from_id and stallreq_from_ex in MC_WAIT do not change the stall encoding (EX encoding already covers them).
- mc_done is registered: it is set only by the transition out of a completing op and is low in every other cycle.
- busy = (state==MC_WAIT).
- Reset (rst=1 at any clock edge, including mid-MC_WAIT):
  - state=RUN, cnt=0, mc_done=0.
  - While rst=1, stall=0, flush=0 and new_pc=0 regardless of inputs.
- Counter arithmetic is unsigned CNT_W-bit. cnt never wraps, because decrement occurs only while cnt>=1.

Optional Feature:
- Macro: STALL_PERF_EN.
- Defined:
  - stall_cnt is a 32-bit register, reset to 0.
  - It increments each cycle in which stall[0]=1 and rst=0.
  - It saturates at 32'hFFFF_FFFF.
  - It is not affected by flush.
- Undefined: the stall_cnt port remains but is tied to 32'h0, and no counter logic is synthesized.

Test Plan:
- Reset: rst=1 with stallreq_from_id=1, flush_req=1, ex_mc_start=1 -> stall=6'b000000, flush=0, new_pc=0, mc_done=0, busy=0. The next cycle after rst is released is in RUN.
- Load-use: stallreq_from_id=1 for one cycle -> stall=6'b000111 in that cycle, 6'b000000 in the next; busy=0 throughout.
- Multi-cycle: ex_mc_start=1 with ex_mc_cycles=4 at cycle 0 -> stall=6'b001111 in cycles 0-3 and busy=1 in cycles 1-3. In cycle 4, mc_done=1 and stall=0. With ex_mc_cycles=0, exactly 1 stall cycle, then mc_done.
- Abort: flush_req=1 with new_pc_i=32'h0000_0020 in cycle 2 of an N=4 op -> flush=1, new_pc=32'h20, stall=0 that cycle. The following cycle is RUN with busy=0, and mc_done never pulses.
- Priority: stallreq_from_id=1 and stallreq_from_ex=1 together -> stall=6'b001111. Adding flush_req=1 -> stall=0, flush=1.
- Perf (STALL_PERF_EN defined): 7 total stall cycles (one load-use cycle plus an N=6 op) -> stall_cnt=7. Without the macro, stall_cnt=0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - central stall/flush controller for the 5-stage MIPS32 pipeline
//
// Purpose:
//   Arbitrates stall requests from ID (load-use) and EX (busy, multi-cycle ops),
//   sequences fixed-latency multi-cycle EX operations with a down-counter and
//   produces the per-stage stall vector plus the flush/redirect for the pipeline.
//
// Optional feature macro: STALL_PERF_EN (stall performance counter on stall_cnt).
//
// Ports:
//   clk              in   system clock, rising edge
//   rst              in   synchronous active-high reset
//   stallreq_from_id in   ID load-use stall request (level)
//   stallreq_from_ex in   EX busy stall request (level)
//   ex_mc_start      in   pulse, EX starts a multi-cycle op
//   ex_mc_cycles     in   latency N of that op (0 treated as 1)
//   flush_req        in   exception/redirect request from MEM
//   new_pc_i         in   redirect target for flush_req
//   stall            out  {WB,MEM,EX,ID,IF,PC} stall vector
//   flush            out  clear all pipeline registers this cycle
//   new_pc           out  redirect PC while flush=1, else 0
//   mc_done          out  one-cycle pulse, multi-cycle op complete
//   busy             out  FSM is in MC_WAIT
//   stall_cnt        out  stall performance counter (0 without STALL_PERF_EN)

module pipe_stall_ctrl #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_cycles,
  input  logic             flush_req,
  input  logic [31:0]      new_pc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             mc_done,
  output logic             busy,
  output logic [31:0]      stall_cnt
);

  localparam logic [5:0]       STALL_EX   = 6'b001111;
  localparam logic [5:0]       STALL_ID   = 6'b000111;
  localparam logic [5:0]       STALL_NONE = 6'b000000;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] mc_n;
  logic             mc_done_nx;
  logic             ex_stall;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      mc_done <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      mc_done <= mc_done_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    mc_done_nx = 1'b0;
    // A zero latency would otherwise never complete; run it as a 1-cycle op.
    mc_n       = (ex_mc_cycles == '0) ? CNT_ONE : ex_mc_cycles;

    if (flush_req) begin
      // Abort anything in flight; no completion pulse follows.
      state_nx = RUN;
      cnt_nx   = '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_mc_start) begin
            if (mc_n == CNT_ONE) begin
              mc_done_nx = 1'b1;
            end else begin
              cnt_nx   = mc_n - CNT_ONE;
              state_nx = MC_WAIT;
            end
          end
        end
        MC_WAIT: begin
          // cnt<=1 rather than ==1 so a corrupted zero count cannot wrap.
          if (cnt <= CNT_ONE) begin
            cnt_nx     = '0;
            state_nx   = RUN;
            mc_done_nx = 1'b1;
          end else begin
            cnt_nx = cnt - CNT_ONE;
          end
        end
        default: begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Output logic: Mealy, the pipeline registers consume these in the same cycle.
  assign ex_stall = (state == MC_WAIT) || ((state == RUN) && ex_mc_start) || stallreq_from_ex;

  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (rst) begin
      stall  = STALL_NONE;
    end else if (flush_req) begin
      flush  = 1'b1;
      new_pc = new_pc_i;
    end else if (ex_stall) begin
      stall  = STALL_EX;
    end else if (stallreq_from_id) begin
      stall  = STALL_ID;
    end
  end

  assign busy = (state == MC_WAIT);

`ifdef STALL_PERF_EN
  logic [31:0] perf_q;

  // Counts PC-stall cycles, saturating; flush does not touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= 32'h0;
    end else if (stall[0] && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'h1;
    end
  end

  assign stall_cnt = perf_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl

module tb_pipe_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        flush_req;
  logic [31:0] new_pc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_done;
  logic        busy;
  logic [31:0] stall_cnt;

  pipe_stall_ctrl #(.CNT_W(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .ex_mc_start      (ex_mc_start),
    .ex_mc_cycles     (ex_mc_cycles),
    .flush_req        (flush_req),
    .new_pc_i         (new_pc_i),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .mc_done          (mc_done),
    .busy             (busy),
    .stall_cnt        (stall_cnt)
  );

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        done;
    logic        busy;
    logic [31:0] scnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] perf_acc = 32'h0;

`ifdef STALL_PERF_EN
  localparam logic [31:0] PERF_TOTAL = 32'd7;
`else
  localparam logic [31:0] PERF_TOTAL = 32'd0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", name, fld, act, exp);
    end
  endtask

  // Monitor: DUT outputs are valid every cycle; compare mid-cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "stall",     {26'h0, stall}, {26'h0, e.stall});
        chk(e.name, "flush",     {31'h0, flush}, {31'h0, e.flush});
        chk(e.name, "new_pc",    new_pc,         e.pc);
        chk(e.name, "mc_done",   {31'h0, mc_done}, {31'h0, e.done});
        chk(e.name, "busy",      {31'h0, busy},  {31'h0, e.busy});
        chk(e.name, "stall_cnt", stall_cnt,      e.scnt);
      end
    end
  end

  task automatic step(
    input string       name,
    input logic        r, id, ex, st,
    input logic [5:0]  n,
    input logic        fl,
    input logic [31:0] pc,
    input logic [5:0]  e_stall,
    input logic        e_fl,
    input logic [31:0] e_pc,
    input logic        e_done, e_busy,
    input bit          push
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stallreq_from_id = id; stallreq_from_ex = ex;
    ex_mc_start = st; ex_mc_cycles = n; flush_req = fl; new_pc_i = pc;
    if (push) begin
      e.name = name; e.stall = e_stall; e.flush = e_fl; e.pc = e_pc;
      e.done = e_done; e.busy = e_busy;
`ifdef STALL_PERF_EN
      e.scnt = perf_acc;
`else
      e.scnt = 32'h0;
`endif
      sb.push_back(e);
    end
    if (r) perf_acc = 32'h0;
    else if (e_stall[0] && perf_acc != 32'hFFFF_FFFF) perf_acc = perf_acc + 32'h1;
  endtask

  initial begin
    rst = 1'b1; stallreq_from_id = 1'b0; stallreq_from_ex = 1'b0;
    ex_mc_start = 1'b0; ex_mc_cycles = 6'd0; flush_req = 1'b0; new_pc_i = 32'h0;

    //   name         rst id ex st n     fl pc            e_stall  fl e_pc          dn bz push
    step("rst1",       1, 1, 0, 1, 6'd4, 1, 32'h1234,    6'h00, 0, 32'h0,      0, 0, 0);
    step("rst2",       1, 1, 1, 1, 6'd4, 1, 32'h1234,    6'h00, 0, 32'h0,      0, 0, 1);
    step("idle0",      0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      0, 0, 1);
    step("lu",         0, 1, 0, 0, 6'd0, 0, 32'h0,       6'h07, 0, 32'h0,      0, 0, 1);
    step("lu_after",   0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      0, 0, 1);
    step("mc4_s",      0, 0, 0, 1, 6'd4, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 0, 1);
    step("mc4_w1",     0, 1, 0, 0, 6'd0, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 1, 1);
    step("mc4_w2",     0, 0, 1, 1, 6'd2, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 1, 1);
    step("mc4_w3",     0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 1, 1);
    step("mc4_done",   0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      1, 0, 1);
    step("mc4_post",   0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      0, 0, 1);
    step("mc0_s",      0, 0, 0, 1, 6'd0, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 0, 1);
    step("mc0_done",   0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      1, 0, 1);
    step("mc1_s",      0, 0, 0, 1, 6'd1, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 0, 1);
    step("mc1_done",   0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      1, 0, 1);
    step("ab_s",       0, 0, 0, 1, 6'd4, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 0, 1);
    step("ab_w1",      0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 1, 1);
    step("ab_flush",   0, 0, 0, 0, 6'd0, 1, 32'h20,      6'h00, 1, 32'h20,     0, 1, 1);
    step("ab_run",     0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      0, 0, 1);
    step("ab_nodone1", 0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      0, 0, 1);
    step("ab_nodone2", 0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      0, 0, 1);
    step("pri_idex",   0, 1, 1, 0, 6'd0, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 0, 1);
    step("pri_flush",  0, 1, 1, 0, 6'd0, 1, 32'h44,      6'h00, 1, 32'h44,     0, 0, 1);
    step("pri_ex",     0, 0, 1, 0, 6'd0, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 0, 1);
    step("pri_idle",   0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      0, 0, 1);
    step("rmc_s",      0, 0, 0, 1, 6'd5, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 0, 1);
    step("rmc_w",      0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 1, 1);
    step("rmc_rst",    1, 1, 1, 0, 6'd0, 1, 32'h88,      6'h00, 0, 32'h0,      0, 1, 1);
    step("rmc_run",    0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      0, 0, 1);
    step("pf_lu",      0, 1, 0, 0, 6'd0, 0, 32'h0,       6'h07, 0, 32'h0,      0, 0, 1);
    step("pf_idle",    0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      0, 0, 1);
    step("pf_s",       0, 0, 0, 1, 6'd6, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 0, 1);
    for (int i = 0; i < 5; i++)
      step("pf_w",     0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h0f, 0, 32'h0,      0, 1, 1);
    step("pf_done",    0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      1, 0, 1);
    #2;
    chk("perf_total", "stall_cnt", stall_cnt, PERF_TOTAL);
    step("end_idle",   0, 0, 0, 0, 6'd0, 0, 32'h0,       6'h00, 0, 32'h0,      0, 0, 1);

    repeat (3) @(posedge clk);
    chk("scoreboard", "drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
